// File: rtl/lsu_stage.sv
// lsu_stage: memory-access pipeline stage between execute and writeback.
// Handles XLEN-generic load/store with lane-shifted byte strobes, load
// alignment and sign/zero extension against a req/ack memory port.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned accesses are not
// issued and complete with out_misalign=1).
module lsu_stage #(
  parameter int XLEN = 64,
  parameter int AW   = 64
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_rd,
  input  logic              in_wb_en,
  input  logic [2:0]        in_wb_sel,
  input  logic [XLEN-1:0]   in_alu_result,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [XLEN-1:0]   in_store_data,
  input  logic              in_load_en,
  input  logic              in_store_en,
  input  logic [1:0]        in_size,
  input  logic              in_unsigned,
  input  logic              in_ebreak,
  output logic              mem_req,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_wstrb,
  input  logic              mem_ack,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4:0]        out_rd,
  output logic              out_wb_en,
  output logic [XLEN-1:0]   out_wb_data,
  output logic              out_ebreak,
  output logic              out_misalign
);

  localparam int SB = XLEN / 8;
  localparam int OW = $clog2(SB);

  typedef enum logic [1:0] {IDLE, MEM, DONE} state_t;

  state_t          state, state_nxt;
  logic            accept;
  logic            is_mem;
  logic            trap;
  logic            mem_go;
  logic [OW-1:0]   in_off;

  // Op fields needed to build the result once the memory access completes
  logic [2:0]      p_wb_sel;
  logic [XLEN-1:0] p_alu;
  logic [XLEN-1:0] p_imm;
  logic [1:0]      p_size;
  logic            p_unsigned;

  // Byte-enable pattern for the access size, shifted to the byte lane
  function automatic logic [SB-1:0] strb_f(input logic [1:0] size, input logic [OW-1:0] off);
    logic [15:0]    m;
    logic [SB+15:0] w;
    case (size)
      2'd0:    m = 16'h0001;
      2'd1:    m = 16'h0003;
      2'd2:    m = 16'h000F;
      default: m = 16'h00FF;
    endcase
    w = {{SB{1'b0}}, m} << off;
    return w[SB-1:0];
  endfunction

  // Right-justify the addressed bytes and extend to XLEN
  function automatic logic [XLEN-1:0] load_ext(input logic [XLEN-1:0] rdata,
                                               input logic [OW-1:0]   off,
                                               input logic [1:0]      size,
                                               input logic            uns);
    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] mask;
    logic            sign;
    sh = rdata >> {off, 3'b000};
    case (size)
      2'd0:    begin mask = XLEN'(8'hFF);         sign = sh[7];      end
      2'd1:    begin mask = XLEN'(16'hFFFF);      sign = sh[15];     end
      2'd2:    begin mask = XLEN'(32'hFFFF_FFFF); sign = sh[31];     end
      default: begin mask = '1;                   sign = sh[XLEN-1]; end
    endcase
    return (uns || !sign) ? (sh & mask) : (sh | ~mask);
  endfunction

  // One-hot writeback source select; anything else yields zero
  function automatic logic [XLEN-1:0] wb_mux(input logic [2:0]      sel,
                                             input logic [XLEN-1:0] alu,
                                             input logic [XLEN-1:0] ld,
                                             input logic [XLEN-1:0] imm);
    case (sel)
      3'b100:  return alu;
      3'b010:  return ld;
      3'b001:  return imm;
      default: return '0;
    endcase
  endfunction

  assign in_ready  = (state == IDLE) || (state == DONE && out_ready);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign is_mem    = in_load_en || in_store_en;
  assign in_off    = in_alu_result[OW-1:0];

`ifdef LSU_MISALIGN_TRAP_EN
  logic misaligned;

  // Address not a multiple of the access size
  always_comb begin
    misaligned = 1'b0;
    case (in_size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = in_alu_result[0];
      2'd2:    misaligned = |in_alu_result[1:0];
      default: misaligned = |in_alu_result[2:0];
    endcase
  end

  assign trap = is_mem && misaligned;
`else
  assign trap = 1'b0;
`endif

  assign mem_go = is_mem && !trap;

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = mem_go ? MEM : DONE;
      MEM:  if (mem_ack) state_nxt = DONE;
      DONE: begin
        if (out_ready) begin
          if (in_valid) state_nxt = mem_go ? MEM : DONE;
          else          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Memory port, pending op fields and registered writeback outputs
  always_ff @(posedge clk) begin
    if (!rstn) begin
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_wstrb    <= '0;
      out_rd       <= '0;
      out_wb_en    <= 1'b0;
      out_wb_data  <= '0;
      out_ebreak   <= 1'b0;
      out_misalign <= 1'b0;
      p_wb_sel     <= '0;
      p_alu        <= '0;
      p_imm        <= '0;
      p_size       <= '0;
      p_unsigned   <= 1'b0;
    end else begin
      if (accept) begin
        out_rd       <= in_rd;
        out_ebreak   <= in_ebreak;
        out_misalign <= trap;
        out_wb_en    <= in_wb_en && !in_store_en && !trap;
        p_wb_sel     <= in_wb_sel;
        p_alu        <= in_alu_result;
        p_imm        <= in_imm;
        p_size       <= in_size;
        p_unsigned   <= in_unsigned;
        if (mem_go) begin
          mem_req   <= 1'b1;
          mem_we    <= in_store_en;
          mem_addr  <= AW'(in_alu_result);
          mem_wdata <= in_store_data << {in_off, 3'b000};
          mem_wstrb <= strb_f(in_size, in_off);
        end else begin
          out_wb_data <= wb_mux(in_wb_sel, in_alu_result, '0, in_imm);
        end
      end
      // Lane offset comes from the held mem_addr, so it need not be stored separately
      if (state == MEM && mem_ack) begin
        mem_req     <= 1'b0;
        out_wb_data <= wb_mux(p_wb_sel, p_alu,
                              load_ext(mem_rdata, mem_addr[OW-1:0], p_size, p_unsigned),
                              p_imm);
      end
    end
  end

endmodule
